// File: rtl/loader_mem_sched_pkg.sv
// Shared types for the loader write scheduler.
// Build option: LOADER_SCHED_FIFO_EN selects a 4-deep loader FIFO;
// without it a single holding register is used.
package loader_sched_pkg;

  // Width of the address field stored in each buffered entry.
  localparam int LDSCHED_ADDR_W = 22;

  // NES phase on which a write window is launched and on which its entry retires.
  localparam logic [1:0] LDSCHED_ISSUE_PHASE = 2'd3;

`ifdef LOADER_SCHED_FIFO_EN
  localparam int LDSCHED_DEPTH = 4;
`else
  localparam int LDSCHED_DEPTH = 1;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2
  } ldsched_state_t;

  typedef struct packed {
    logic [LDSCHED_ADDR_W-1:0] addr;
    logic [7:0]                data;
  } ld_entry_t;

endpackage

// File: rtl/loader_mem_sched_if.sv
// Loader write port, CPU request port and SDRAM port-A bus of the scheduler.
// The master side is the loader/CPU/SDRAM environment; the slave side is the scheduler.
interface loader_mem_sched_if #(
  parameter int ADDR_W     = 22,
  parameter int MEM_ADDR_W = 25
);
  logic                  ld_wr;
  logic [ADDR_W-1:0]     ld_addr;
  logic [7:0]            ld_data;
  logic                  ld_ready;

  logic [ADDR_W-1:0]     cpu_addr;
  logic                  cpu_rd;
  logic                  cpu_wr;
  logic [7:0]            cpu_dout;

  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [7:0]            mem_din;
  logic                  mem_we;
  logic                  mem_oe;

  modport master (
    output ld_wr, ld_addr, ld_data, cpu_addr, cpu_rd, cpu_wr, cpu_dout,
    input  ld_ready, mem_addr, mem_din, mem_we, mem_oe
  );

  modport slave (
    input  ld_wr, ld_addr, ld_data, cpu_addr, cpu_rd, cpu_wr, cpu_dout,
    output ld_ready, mem_addr, mem_din, mem_we, mem_oe
  );
endinterface

// File: rtl/loader_sched_fifo.sv
// Parameterised-depth synchronous FIFO with occupancy count.
// A push while full is accepted only when a pop happens in the same clock
// (the pop frees the slot first). Full/empty are registered so the
// loader-side ready needs no combinational path from the count.
module loader_sched_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 30,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             drop
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic             empty;
  logic             do_push, do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  // An empty FIFO presents zero at its head rather than stale storage.
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Next occupancy from this clock's accepted push/pop.
  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Entry storage; deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers, count and registered full/empty flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end
endmodule

// File: rtl/loader_mem_sched.sv
// Loader write scheduler and SDRAM port-A arbiter.
// Buffered loader bytes are written as 4-clock windows aligned to NES phase
// 0..3; while loading is active the loader owns port A, otherwise the CPU
// request passes straight through.
// Build option: LOADER_SCHED_FIFO_EN (4-deep buffer; default is one entry).
//
// state | meaning
// IDLE  | nothing buffered, no window in progress
// WAIT  | entry buffered, waiting for NES phase 3 to launch a window
// ISSUE | write window active (phases 0..3); head retires on phase 3
module loader_mem_sched
  import loader_sched_pkg::*;
#(
  parameter int ADDR_W     = 22,
  parameter int MEM_ADDR_W = 25
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         nes_ce,
  input  logic               downloading,
  input  logic               loader_busy,
  loader_mem_sched_if.slave  bus,
  output logic [2:0]         pending,
  output logic               overflow
);
  localparam int CNT_W = $clog2(LDSCHED_DEPTH + 1);

  ldsched_state_t   state;
  logic             we_q;
  logic             dl_q;
  ld_entry_t        wr_entry, head;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_full, drop;
  logic             pop, push_ok, more_left, ld_mode;

  assign wr_entry = {LDSCHED_ADDR_W'(bus.ld_addr[ADDR_W-1:0]), bus.ld_data};

  loader_sched_fifo #(
    .DEPTH (LDSCHED_DEPTH),
    .W     ($bits(ld_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (bus.ld_wr),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .count (fifo_cnt),
    .full  (fifo_full),
    .drop  (drop)
  );

  assign bus.ld_ready = ~fifo_full;
  assign pending      = 3'(fifo_cnt);

  assign pop       = (state == ISSUE) && (nes_ce == LDSCHED_ISSUE_PHASE);
  assign push_ok   = bus.ld_wr & ~drop;
  // The popped entry is still counted, so anything beyond it (or a push in
  // the same clock) means another window follows without a gap.
  assign more_left = (fifo_cnt != CNT_W'(1)) | push_ok;

  assign ld_mode = downloading | loader_busy | (fifo_cnt != '0) | (state != IDLE);

  // Window sequencer; mem_we for loader writes is registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      we_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_cnt != '0) state <= WAIT;
        end
        WAIT: begin
          if (nes_ce == LDSCHED_ISSUE_PHASE) begin
            state <= ISSUE;
            we_q  <= 1'b1;
          end
        end
        ISSUE: begin
          if (pop && !more_left) begin
            state <= IDLE;
            we_q  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          we_q  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky drop flag; cleared by a new download starting, but a drop wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_q     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      dl_q <= downloading;
      if (drop)                     overflow <= 1'b1;
      else if (downloading && !dl_q) overflow <= 1'b0;
    end
  end

  // Port-A mux: loader head during loading, CPU pass-through otherwise.
  always_comb begin
    bus.mem_addr = MEM_ADDR_W'(bus.cpu_addr);
    bus.mem_din  = bus.cpu_dout;
    bus.mem_we   = bus.cpu_wr;
    bus.mem_oe   = bus.cpu_rd;
    if (ld_mode) begin
      bus.mem_addr = MEM_ADDR_W'(head.addr);
      bus.mem_din  = head.data;
      bus.mem_we   = we_q;
      bus.mem_oe   = 1'b0;
    end
  end
endmodule

// File: tb/tb_loader_mem_sched.sv
// Directed bench for loader_mem_sched; follows LOADER_SCHED_FIFO_EN for depth.
module tb_loader_mem_sched;
`ifdef LOADER_SCHED_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] nes_ce;
  logic       downloading, loader_busy;
  logic [2:0] pending;
  logic       overflow;

  loader_mem_sched_if #(.ADDR_W(22), .MEM_ADDR_W(25)) bus ();

  loader_mem_sched #(.ADDR_W(22), .MEM_ADDR_W(25)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .nes_ce      (nes_ce),
    .downloading (downloading),
    .loader_busy (loader_busy),
    .bus         (bus),
    .pending     (pending),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [21:0] exp_addr [4];
  logic [7:0]  exp_data [4];
  logic        rec_we   [48];
  logic [24:0] rec_addr [48];
  logic [7:0]  rec_din  [48];
  logic [1:0]  rec_ce   [48];

  // One clock: inputs and samples live at posedge+1, nes_ce advances with the edge.
  task automatic step();
    @(posedge clk);
    #1;
    nes_ce = nes_ce + 2'd1;
  endtask

  task automatic wait_ce(input logic [1:0] v);
    for (int k = 0; k < 4 && nes_ce != v; k++) step();
  endtask

  task automatic fill(input logic [21:0] base);
    wait_ce(2'd0);
    for (int i = 0; i < DEPTH; i++) begin
      exp_addr[i] = base + 22'(i * 'h111);
      exp_data[i] = 8'h30 + 8'(i);
      bus.ld_wr   = 1'b1;
      bus.ld_addr = exp_addr[i];
      bus.ld_data = exp_data[i];
      step();
    end
    bus.ld_wr = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((pending != 3'd0 || bus.mem_we) && k < 60) begin
      step();
      k++;
    end
    n_cmp++;
    if (pending !== 3'd0 || bus.mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL drain: pending=%0d mem_we=%0b, required 0/0", pending, bus.mem_we);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; nes_ce = 2'd0; downloading = 1'b0; loader_busy = 1'b0;
    bus.ld_wr = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.cpu_addr = 22'h001234; bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_dout = 8'h77;
    #12;
    n_cmp++;
    if (bus.ld_ready !== 1'b1 || pending !== 3'd0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: ld_ready=%0b pending=%0d overflow=%0b, required 1/0/0",
               bus.ld_ready, pending, overflow);
    end
    n_cmp++;
    if (bus.mem_addr !== 25'h0001234 || bus.mem_din !== 8'h77 || bus.mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL reset_passthru: addr=%h din=%h we=%0b, required 0001234/77/0",
               bus.mem_addr, bus.mem_din, bus.mem_we);
    end
    loader_busy = 1'b1;
    #1;
    n_cmp++;
    if (bus.mem_addr !== 25'h0 || bus.mem_din !== 8'h0) begin
      n_err++;
      $display("FAIL reset_loader_head: addr=%h din=%h, required 0/0", bus.mem_addr, bus.mem_din);
    end
    loader_busy = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_arbitration();
    bus.cpu_rd = 1'b1; bus.cpu_addr = 22'h002000;
    #1;
    n_cmp++;
    if (bus.mem_oe !== 1'b1 || bus.mem_addr !== 25'h0002000 || bus.mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL arb_cpu_rd: oe=%0b addr=%h we=%0b, required 1/0002000/0",
               bus.mem_oe, bus.mem_addr, bus.mem_we);
    end
    bus.cpu_wr = 1'b1; bus.cpu_dout = 8'h5A;
    #1;
    n_cmp++;
    if (bus.mem_we !== 1'b1 || bus.mem_din !== 8'h5A) begin
      n_err++;
      $display("FAIL arb_cpu_wr: we=%0b din=%h, required 1/5a", bus.mem_we, bus.mem_din);
    end
    loader_busy = 1'b1;
    #1;
    n_cmp++;
    if (bus.mem_oe !== 1'b0 || bus.mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL arb_loader_block: oe=%0b we=%0b, required 0/0", bus.mem_oe, bus.mem_we);
    end
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; loader_busy = 1'b0;
    step();
  endtask

  task automatic test_single();
    loader_busy = 1'b1;
    wait_ce(2'd1);
    bus.ld_wr = 1'b1; bus.ld_addr = 22'h012345; bus.ld_data = 8'hA5;
    step();
    bus.ld_wr = 1'b0;
    n_cmp++;
    if (pending !== 3'd1) begin
      n_err++;
      $display("FAIL single_pending: got %0d, required 1", pending);
    end
    step();
    n_cmp++;
    if (bus.mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL single_we_early: got %0b, required 0", bus.mem_we);
    end
    step();
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== 25'h0012345 || bus.mem_din !== 8'hA5) begin
        n_err++;
        $display("FAIL single_window[%0d]: we=%0b addr=%h din=%h, required 1/0012345/a5",
                 c, bus.mem_we, bus.mem_addr, bus.mem_din);
      end
      step();
    end
    n_cmp++;
    if (bus.mem_we !== 1'b0 || pending !== 3'd0) begin
      n_err++;
      $display("FAIL single_end: we=%0b pending=%0d, required 0/0", bus.mem_we, pending);
    end
    loader_busy = 1'b0;
    step();
  endtask

  task automatic test_burst();
    int f;
    int nwe;
    logic ok;
    loader_busy = 1'b1;
    fill(22'h100000);
    n_cmp++;
    if (pending !== 3'(DEPTH) || bus.ld_ready !== 1'b0) begin
      n_err++;
      $display("FAIL burst_full: pending=%0d ld_ready=%0b, required %0d/0",
               pending, bus.ld_ready, DEPTH);
    end
    for (int j = 0; j < 48; j++) begin
      rec_we[j] = bus.mem_we; rec_addr[j] = bus.mem_addr;
      rec_din[j] = bus.mem_din; rec_ce[j] = nes_ce;
      if (j == 0) begin
        bus.ld_wr = 1'b1; bus.ld_addr = 22'h3FFFFF; bus.ld_data = 8'hEE;
      end
      step();
      bus.ld_wr = 1'b0;
    end
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL burst_overflow: got %0b, required 1", overflow);
    end
    f = -1;
    nwe = 0;
    for (int j = 0; j < 48; j++) begin
      if (rec_we[j]) nwe++;
      if (f < 0 && rec_we[j]) f = j;
    end
    n_cmp++;
    if (f < 0 || f > 47 - 4 * DEPTH || rec_ce[f] !== 2'd0 || nwe != 4 * DEPTH) begin
      n_err++;
      $display("FAIL burst_windows: first=%0d we_clks=%0d, required phase-0 start and %0d clks",
               f, nwe, 4 * DEPTH);
    end else begin
      for (int w = 0; w < DEPTH; w++) begin
        ok = 1'b1;
        for (int c = 0; c < 4; c++)
          if (rec_we[f + 4 * w + c] !== 1'b1 || rec_addr[f + 4 * w + c] !== {3'b0, exp_addr[w]} ||
              rec_din[f + 4 * w + c] !== exp_data[w]) ok = 1'b0;
        n_cmp++;
        if (!ok) begin
          n_err++;
          $display("FAIL burst_entry[%0d]: addr=%h din=%h, required %h/%h for 4 clks",
                   w, rec_addr[f + 4 * w], rec_din[f + 4 * w], exp_addr[w], exp_data[w]);
        end
      end
    end
    n_cmp++;
    if (pending !== 3'd0) begin
      n_err++;
      $display("FAIL burst_pending_end: got %0d, required 0", pending);
    end
    loader_busy = 1'b0;
    step();
  endtask

  task automatic test_full_push_pop();
    logic [24:0] last_addr;
    logic [7:0]  last_din;
    int k;
    loader_busy = 1'b1;
    fill(22'h200000);
    k = 0;
    while (!(bus.mem_we === 1'b1 && nes_ce == 2'd3) && k < 16) begin
      step();
      k++;
    end
    n_cmp++;
    if (pending !== 3'(DEPTH) || bus.mem_we !== 1'b1) begin
      n_err++;
      $display("FAIL pushpop_pre: pending=%0d we=%0b, required %0d/1", pending, bus.mem_we, DEPTH);
    end
    bus.ld_wr = 1'b1; bus.ld_addr = 22'h2ABCDE; bus.ld_data = 8'hC3;
    step();
    bus.ld_wr = 1'b0;
    n_cmp++;
    if (pending !== 3'(DEPTH) || bus.mem_we !== 1'b1) begin
      n_err++;
      $display("FAIL pushpop_count: pending=%0d we=%0b, required %0d/1", pending, bus.mem_we, DEPTH);
    end
    last_addr = '0; last_din = '0;
    k = 0;
    while ((pending != 3'd0 || bus.mem_we) && k < 60) begin
      if (bus.mem_we) begin
        last_addr = bus.mem_addr;
        last_din  = bus.mem_din;
      end
      step();
      k++;
    end
    n_cmp++;
    if (last_addr !== 25'h02ABCDE || last_din !== 8'hC3 || pending !== 3'd0) begin
      n_err++;
      $display("FAIL pushpop_last: addr=%h din=%h pending=%0d, required 02abcde/c3/0",
               last_addr, last_din, pending);
    end
    loader_busy = 1'b0;
    step();
  endtask

  task automatic test_overflow_clear();
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_pre: got %0b, required 1", overflow);
    end
    downloading = 1'b1;
    step();
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear: got %0b, required 0", overflow);
    end
    downloading = 1'b0;
    step();
  endtask

  task automatic test_overflow_set_wins();
    loader_busy = 1'b1;
    fill(22'h300000);
    bus.ld_wr = 1'b1; bus.ld_addr = 22'h3F0000; bus.ld_data = 8'h11;
    downloading = 1'b1;
    step();
    bus.ld_wr = 1'b0;
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_set_wins: got %0b, required 1", overflow);
    end
    drain();
    downloading = 1'b0; loader_busy = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_window();
    logic seen;
    int k;
    wait_ce(2'd1);
    bus.ld_wr = 1'b1; bus.ld_addr = 22'h0ABCDE; bus.ld_data = 8'h05;
    step();
    bus.ld_wr = 1'b0;
    k = 0;
    while (bus.mem_we !== 1'b1 && k < 8) begin
      step();
      k++;
    end
    n_cmp++;
    if (bus.mem_we !== 1'b1) begin
      n_err++;
      $display("FAIL rstwin_start: we=%0b, required 1", bus.mem_we);
    end
    step();
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.mem_we !== 1'b0 || pending !== 3'd0 || overflow !== 1'b0 || bus.ld_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rstwin_async: we=%0b pending=%0d overflow=%0b ld_ready=%0b, required 0/0/0/1",
               bus.mem_we, pending, overflow, bus.ld_ready);
    end
    step();
    step();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 12; j++) begin
      step();
      if (bus.mem_we !== 1'b0 || pending !== 3'd0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL rstwin_no_issue: activity=%0b, required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_single();
    test_burst();
    test_full_push_pop();
    test_overflow_clear();
    test_overflow_set_wins();
    test_reset_mid_window();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
